// File: rtl/prog_timer.sv
// prog_timer
//   Runtime-programmable prescaled timer/counter. The counter counts up from 0
//   to the latched top value and wraps, once every (prescale+1) clocks. It runs
//   either once (one-shot) or continuously (auto-reload). The compare output
//   gives a duty-cycle window at the start of every period.
//
// Ports
//   clkIN        system clock, rising edge
//   nResetIN     asynchronous reset, active-low
//   enableIN     gates ticks; low freezes prescaler and counter
//   startIN      start / retrigger request
//   stopIN       abort request (wins over startIN)
//   oneShotIN    1 = one-shot, 0 = auto-reload
//   prescaleIN   prescaler terminal value
//   topIN        counter terminal value (period = top+1 ticks)
//   compareIN    compare threshold
//   counterOUT   current count
//   runningOUT   high while in RUN
//   compareOUT   runningOUT && counter < compare shadow
//   overflowOUT  one-cycle pulse on wrap
//   doneOUT      one-cycle pulse on one-shot completion
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | stopped; counter and prescaler held at 0, no pulses
// RUN   | counting; ticks advance the counter, wraps pulse overflowOUT
module prog_timer #(
  parameter int WIDTH       = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clkIN,
  input  logic                   nResetIN,
  input  logic                   enableIN,
  input  logic                   startIN,
  input  logic                   stopIN,
  input  logic                   oneShotIN,
  input  logic [PRESC_WIDTH-1:0] prescaleIN,
  input  logic [WIDTH-1:0]       topIN,
  input  logic [WIDTH-1:0]       compareIN,
  output logic [WIDTH-1:0]       counterOUT,
  output logic                   runningOUT,
  output logic                   compareOUT,
  output logic                   overflowOUT,
  output logic                   doneOUT
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stateT;

  stateT                  state, stateNext;
  logic [WIDTH-1:0]       counter, counterNext;
  logic [PRESC_WIDTH-1:0] presc, prescNext;
  logic                   overflowNext, doneNext;
  logic                   loadShadow;

  logic [WIDTH-1:0]       topSh;
  logic [WIDTH-1:0]       compareSh;
  logic [PRESC_WIDTH-1:0] prescSh;
  logic                   oneShotSh;

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state       <= IDLE;
      counter     <= '0;
      presc       <= '0;
      overflowOUT <= 1'b0;
      doneOUT     <= 1'b0;
      topSh       <= '0;
      compareSh   <= '0;
      prescSh     <= '0;
      oneShotSh   <= 1'b0;
    end else begin
      state       <= stateNext;
      counter     <= counterNext;
      presc       <= prescNext;
      overflowOUT <= overflowNext;
      doneOUT     <= doneNext;
      if (loadShadow) begin
        topSh     <= topIN;
        compareSh <= compareIN;
        prescSh   <= prescaleIN;
        oneShotSh <= oneShotIN;
      end
    end
  end

  // Priority on every edge: stop, then start/retrigger, then tick.
  always_comb begin
    stateNext    = state;
    counterNext  = counter;
    prescNext    = presc;
    overflowNext = 1'b0;
    doneNext     = 1'b0;
    loadShadow   = 1'b0;

    unique case (state)
      IDLE: begin
        if (stopIN) begin
          counterNext = '0;
          prescNext   = '0;
        end else if (startIN) begin
          stateNext   = RUN;
          counterNext = '0;
          prescNext   = '0;
          loadShadow  = 1'b1;
        end
      end

      RUN: begin
        if (stopIN) begin
          stateNext   = IDLE;
          counterNext = '0;
          prescNext   = '0;
        end else if (startIN) begin
          counterNext = '0;
          prescNext   = '0;
          loadShadow  = 1'b1;
        end else if (enableIN) begin
          if (presc == prescSh) begin
            prescNext = '0;
            if (counter == topSh) begin
              counterNext  = '0;
              overflowNext = 1'b1;
              if (oneShotSh) begin
                stateNext = IDLE;
                doneNext  = 1'b1;
              end else begin
                // New settings take effect cleanly at a period boundary.
                loadShadow = 1'b1;
              end
            end else begin
              counterNext = counter + 1'b1;
            end
          end else begin
            prescNext = presc + 1'b1;
          end
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  assign counterOUT = counter;
  assign runningOUT = (state == RUN);
  assign compareOUT = runningOUT && (counter < compareSh);

endmodule

// File: tb/tb_prog_timer.sv
module tb_prog_timer;

  logic        clkIN = 1'b0;
  logic        nResetIN;
  logic        enableIN;
  logic        startIN;
  logic        stopIN;
  logic        oneShotIN;
  logic [7:0]  prescaleIN;
  logic [15:0] topIN;
  logic [15:0] compareIN;
  logic [15:0] counterOUT;
  logic        runningOUT;
  logic        compareOUT;
  logic        overflowOUT;
  logic        doneOUT;

  prog_timer #(.WIDTH(16), .PRESC_WIDTH(8)) dut (
    .clkIN      (clkIN),
    .nResetIN   (nResetIN),
    .enableIN   (enableIN),
    .startIN    (startIN),
    .stopIN     (stopIN),
    .oneShotIN  (oneShotIN),
    .prescaleIN (prescaleIN),
    .topIN      (topIN),
    .compareIN  (compareIN),
    .counterOUT (counterOUT),
    .runningOUT (runningOUT),
    .compareOUT (compareOUT),
    .overflowOUT(overflowOUT),
    .doneOUT    (doneOUT)
  );

  always #5 clkIN = ~clkIN;

  typedef struct {
    logic        start;
    logic        stop;
    logic        en;
    logic        oneShot;
    logic [7:0]  presc;
    logic [15:0] top;
    logic [15:0] cmp;
    logic [15:0] eCnt;
    logic        eRun;
    logic        eCmp;
    logic        eOvf;
    logic        eDone;
  } vecT;

  vecT vecs[$];

  int checks = 0;
  int errors = 0;

  logic        cOs;
  logic [7:0]  cPre;
  logic [15:0] cTop;
  logic [15:0] cCmp;
  logic        cEn;

  task automatic cfg(input logic os, input logic [7:0] pre,
                     input logic [15:0] top, input logic [15:0] cmp);
    cOs = os; cPre = pre; cTop = top; cCmp = cmp;
  endtask

  // One row: inputs held across an edge, outputs expected just after it.
  task automatic addVec(input logic s, input logic p, input logic [15:0] cnt,
                        input logic r, input logic c, input logic o, input logic d);
    vecT v;
    v.start = s; v.stop = p; v.en = cEn; v.oneShot = cOs;
    v.presc = cPre; v.top = cTop; v.cmp = cCmp;
    v.eCnt = cnt; v.eRun = r; v.eCmp = c; v.eOvf = o; v.eDone = d;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d] got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkIN);
    #1;
  endtask

  task automatic checkAll(input string nm, input int idx, input logic [15:0] cnt,
                          input logic r, input logic c, input logic o, input logic d);
    chk({nm, ".counter"},  idx, 32'(counterOUT),  32'(cnt));
    chk({nm, ".running"},  idx, 32'(runningOUT),  32'(r));
    chk({nm, ".compare"},  idx, 32'(compareOUT),  32'(c));
    chk({nm, ".overflow"}, idx, 32'(overflowOUT), 32'(o));
    chk({nm, ".done"},     idx, 32'(doneOUT),     32'(d));
  endtask

  // Edges from just after one overflow pulse to the next; enable is dropped
  // for five edges starting at edge number enLowAt+1.
  task automatic ovfGap(input int enLowAt, output int gap);
    gap = 0;
    for (int i = 0; i < 60; i++) begin
      enableIN = (gap >= enLowAt && gap < enLowAt + 5) ? 1'b0 : 1'b1;
      tick();
      gap++;
      if (overflowOUT) break;
    end
    enableIN = 1'b1;
    if (!overflowOUT) gap = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int found;

    cEn = 1'b1;
    cfg(0, 0, 0, 0);

    // auto-reload, top 3, prescale 0, compare 2
    cfg(0, 0, 3, 2);
    addVec(1, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 1, 0, 0);
    addVec(0, 0, 2, 1, 0, 0, 0);
    addVec(0, 0, 3, 1, 0, 0, 0);
    addVec(0, 0, 0, 1, 1, 1, 0);
    addVec(0, 0, 1, 1, 1, 0, 0);
    addVec(0, 0, 2, 1, 0, 0, 0);
    addVec(0, 0, 3, 1, 0, 0, 0);
    addVec(0, 0, 0, 1, 1, 1, 0);
    addVec(0, 1, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 0, 0, 0);  // stop beats start in IDLE

    // top 1, prescale 2: counter moves every 3 clocks
    cfg(0, 2, 1, 1);
    addVec(1, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 0, 1, 1, 1, 0);
    cEn = 1'b0;
    addVec(0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 0, 1, 1, 0, 0);
    cEn = 1'b1;
    addVec(0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 0, 0, 0);
    addVec(0, 1, 0, 0, 0, 0, 0);

    // one-shot, top 4; mode input dropped mid-run must not matter
    cfg(1, 0, 4, 0);
    addVec(1, 0, 0, 1, 0, 0, 0);
    cOs = 1'b0;
    addVec(0, 0, 1, 1, 0, 0, 0);
    addVec(0, 0, 2, 1, 0, 0, 0);
    addVec(0, 0, 3, 1, 0, 0, 0);
    addVec(0, 0, 4, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 1, 1);
    addVec(0, 0, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0);

    // PWM top 9 compare 3, compare changed to 7 mid-period
    cfg(0, 0, 9, 3);
    addVec(1, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 1, 0, 0);
    addVec(0, 0, 2, 1, 1, 0, 0);
    addVec(0, 0, 3, 1, 0, 0, 0);
    addVec(0, 0, 4, 1, 0, 0, 0);
    cCmp = 16'd7;
    for (int i = 5; i <= 9; i++) addVec(0, 0, 16'(i), 1, 0, 0, 0);
    addVec(0, 0, 0, 1, 1, 1, 0);
    for (int i = 1; i <= 6; i++) addVec(0, 0, 16'(i), 1, 1, 0, 0);
    for (int i = 7; i <= 9; i++) addVec(0, 0, 16'(i), 1, 0, 0, 0);
    addVec(0, 0, 0, 1, 1, 1, 0);
    addVec(0, 0, 1, 1, 1, 0, 0);
    addVec(0, 0, 2, 1, 1, 0, 0);

    // stop and start together at counter 2
    addVec(1, 1, 0, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 0);

    // retrigger at counter 2
    cfg(0, 0, 9, 3);
    addVec(1, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 1, 0, 0);
    addVec(0, 0, 2, 1, 1, 0, 0);
    addVec(1, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 1, 0, 0);
    addVec(0, 0, 2, 1, 1, 0, 0);
    addVec(0, 0, 3, 1, 0, 0, 0);

    // compare above top: high for the whole period
    cfg(0, 0, 2, 15);
    addVec(1, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 1, 1, 0, 0);
    addVec(0, 0, 2, 1, 1, 0, 0);
    addVec(0, 0, 0, 1, 1, 1, 0);
    addVec(0, 0, 1, 1, 1, 0, 0);

    // top 0, prescale 0: overflow continuously high
    cfg(0, 0, 0, 0);
    addVec(1, 0, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 1, 0, 1, 0);
    addVec(0, 0, 0, 1, 0, 1, 0);
    addVec(0, 0, 0, 1, 0, 1, 0);
    addVec(0, 1, 0, 0, 0, 0, 0);

    // reset state
    nResetIN = 1'b0;
    enableIN = 1'b1; startIN = 1'b0; stopIN = 1'b0; oneShotIN = 1'b0;
    prescaleIN = '0; topIN = 16'd5; compareIN = 16'd3;
    tick();
    tick();
    checkAll("reset", 0, 0, 0, 0, 0, 0);
    nResetIN = 1'b1;
    tick();
    checkAll("idle", 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      startIN    = vecs[i].start;
      stopIN     = vecs[i].stop;
      enableIN   = vecs[i].en;
      oneShotIN  = vecs[i].oneShot;
      prescaleIN = vecs[i].presc;
      topIN      = vecs[i].top;
      compareIN  = vecs[i].cmp;
      tick();
      checkAll("tbl", i, vecs[i].eCnt, vecs[i].eRun, vecs[i].eCmp,
               vecs[i].eOvf, vecs[i].eDone);
    end
    startIN = 1'b0; stopIN = 1'b0; enableIN = 1'b1;

    // overflow period 6, stretched to 11 by five disabled clocks
    oneShotIN = 1'b0; prescaleIN = 8'd2; topIN = 16'd1; compareIN = 16'd1;
    startIN = 1'b1;
    tick();
    startIN = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (overflowOUT) begin
        found = 1;
        break;
      end
    end
    chk("first_ovf_seen", 0, 32'(found), 32'd1);
    ovfGap(1000, gap);
    chk("ovf_period", 0, 32'(gap), 32'd6);
    ovfGap(2, gap);
    chk("ovf_period_stretched", 0, 32'(gap), 32'd11);
    ovfGap(1000, gap);
    chk("ovf_period_after", 0, 32'(gap), 32'd6);
    stopIN = 1'b1;
    tick();
    stopIN = 1'b0;

    // asynchronous reset between edges at counter 5
    prescaleIN = 8'd0; topIN = 16'd9; compareIN = 16'd8;
    startIN = 1'b1;
    tick();
    startIN = 1'b0;
    repeat (5) tick();
    chk("pre_reset.counter", 0, 32'(counterOUT), 32'd5);
    chk("pre_reset.compare", 0, 32'(compareOUT), 32'd1);
    #2;
    nResetIN = 1'b0;
    #1;
    checkAll("async_reset", 0, 0, 0, 0, 0, 0);
    #2;
    nResetIN = 1'b1;
    tick();
    checkAll("post_reset", 0, 0, 0, 0, 0, 0);
    tick();
    checkAll("post_reset", 1, 0, 0, 0, 0, 0);
    startIN = 1'b1;
    tick();
    startIN = 1'b0;
    checkAll("restart", 0, 0, 1, 1, 0, 0);
    tick();
    checkAll("restart", 1, 1, 1, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
